vga_timing_gen: RTL and testbench

//  640x480@60 Hz VGA raster timing generator; upstream of the pixel/sprite pipeline in Top.

---
 rtl/vga_pkg.sv | 42 ++++
 rtl/vga_sync_delay.sv | 33 +++
 rtl/vga_timing_gen.sv | 185 ++++++++++++++++++
 tb/tb_vga_timing_gen.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA 640x480@60 timing constants, FSM state type and test-pattern colour table.
// Coordinates are signed so that the visible area starts at (0,0) and blanking is negative.
package vga_pkg;

  localparam int CORDW  = 16;

  localparam int H_FP   = 16;
  localparam int H_SYNC = 96;
  localparam int H_BP   = 48;
  localparam int H_ACT  = 640;

  localparam int V_FP   = 10;
  localparam int V_SYNC = 2;
  localparam int V_BP   = 33;
  localparam int V_ACT  = 480;

  localparam int H_STA  = -(H_FP + H_SYNC + H_BP);
  localparam int V_STA  = -(V_FP + V_SYNC + V_BP);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } vga_state_e;

  // Eight vertical bars, left to right, as {r,g,b}.
  function automatic logic [23:0] tp_colour(input logic [2:0] idx);
    logic [23:0] rgb;
    case (idx)
      3'd0:    rgb = 24'hFF_FF_FF;
      3'd1:    rgb = 24'hFF_FF_00;
      3'd2:    rgb = 24'h00_FF_FF;
      3'd3:    rgb = 24'h00_FF_00;
      3'd4:    rgb = 24'hFF_00_FF;
      3'd5:    rgb = 24'hFF_00_00;
      3'd6:    rgb = 24'h00_00_FF;
      default: rgb = 24'h00_00_00;
    endcase
    return rgb;
  endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// DEPTH-stage shift register that realigns sync/blank (and test-pattern RGB) with the
// downstream registered RGB stage. DEPTH=0 is a straight wire.
module vga_sync_delay #(
  parameter int             DEPTH   = 1,
  parameter int             W       = 3,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         i_clk_25,
  input  logic         i_rst_n,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  generate
    if (DEPTH == 0) begin : g_bypass
      assign o_q = i_d;
    end else begin : g_pipe
      logic [W-1:0] r_pipe [DEPTH];

      always_ff @(posedge i_clk_25 or negedge i_rst_n) begin
        if (!i_rst_n) begin
          for (int i = 0; i < DEPTH; i++) r_pipe[i] <= RST_VAL;
        end else begin
          r_pipe[0] <= i_d;
          for (int i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
        end
      end

      assign o_q = r_pipe[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator with frame-boundary start/stop control and delayed sync/blank.
// Optional macro VGA_TESTPAT_EN adds an 8-bar colour test pattern on o_tp_r/o_tp_g/o_tp_b.
module vga_timing_gen #(
  parameter int CORDW      = vga_pkg::CORDW,
  parameter int SYNC_DELAY = 1,
  parameter int FCNT_W     = 16,
  parameter int HFP        = vga_pkg::H_FP,
  parameter int HSW        = vga_pkg::H_SYNC,
  parameter int HBP        = vga_pkg::H_BP,
  parameter int HACT       = vga_pkg::H_ACT,
  parameter int VFP        = vga_pkg::V_FP,
  parameter int VSW        = vga_pkg::V_SYNC,
  parameter int VBP        = vga_pkg::V_BP,
  parameter int VACT       = vga_pkg::V_ACT
) (
  input  logic              i_clk_25,
  input  logic              i_rst_n,
  input  logic              i_start_display,
  output logic [CORDW-1:0]  o_sx,
  output logic [CORDW-1:0]  o_sy,
  output logic              o_de,
  output logic              o_line,
  output logic              o_frame,
  output logic              o_hs,
  output logic              o_vs,
  output logic              o_blank_n,
  output logic              o_sync_n,
  output logic [FCNT_W-1:0] o_frame_cnt,
  output logic              o_running,
  output logic [1:0]        o_dbg_state
`ifdef VGA_TESTPAT_EN
  ,
  output logic [7:0]        o_tp_r,
  output logic [7:0]        o_tp_g,
  output logic [7:0]        o_tp_b
`endif
);

  import vga_pkg::*;

  localparam int HSTA = -(HFP + HSW + HBP);
  localparam int VSTA = -(VFP + VSW + VBP);

  localparam logic signed [CORDW-1:0] C_HSTA   = CORDW'(HSTA);
  localparam logic signed [CORDW-1:0] C_HEND   = CORDW'(HACT - 1);
  localparam logic signed [CORDW-1:0] C_HS_BEG = CORDW'(HSTA + HFP);
  localparam logic signed [CORDW-1:0] C_HS_END = CORDW'(HSTA + HFP + HSW - 1);
  localparam logic signed [CORDW-1:0] C_VSTA   = CORDW'(VSTA);
  localparam logic signed [CORDW-1:0] C_VEND   = CORDW'(VACT - 1);
  localparam logic signed [CORDW-1:0] C_VS_BEG = CORDW'(VSTA + VFP);
  localparam logic signed [CORDW-1:0] C_VS_END = CORDW'(VSTA + VFP + VSW - 1);
  localparam logic signed [CORDW-1:0] C_ONE    = CORDW'(1);
  localparam logic [FCNT_W-1:0]       C_FCNT_ONE = FCNT_W'(1);

  vga_state_e               r_state;
  logic signed [CORDW-1:0]  r_sx, r_sy;
  logic                     r_de, r_line, r_frame, r_hs, r_vs, r_running;
  logic [FCNT_W-1:0]        r_fcnt;

  logic signed [CORDW-1:0]  w_nx, w_ny;
  logic                     w_eol, w_wrap, w_stop_now;
  logic                     w_n_de, w_n_hs, w_n_vs;

  // Next raster position and its decoded sync/active flags.
  always_comb begin
    w_eol      = (r_sx == C_HEND);
    w_wrap     = w_eol && (r_sy == C_VEND);
    w_stop_now = w_wrap && !i_start_display;
    w_nx       = w_eol ? C_HSTA : r_sx + C_ONE;
    w_ny       = r_sy;
    if (w_eol) w_ny = (r_sy == C_VEND) ? C_VSTA : r_sy + C_ONE;
    w_n_de = !w_nx[CORDW-1] && !w_ny[CORDW-1];
    w_n_hs = !((w_nx >= C_HS_BEG) && (w_nx <= C_HS_END));
    w_n_vs = !((w_ny >= C_VS_BEG) && (w_ny <= C_VS_END));
  end

  // Start is sampled continuously; stopping is only honoured at the frame wrap.
  always_ff @(posedge i_clk_25 or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= IDLE;
      r_sx      <= C_HSTA;
      r_sy      <= C_VSTA;
      r_de      <= 1'b0;
      r_line    <= 1'b0;
      r_frame   <= 1'b0;
      r_hs      <= 1'b1;
      r_vs      <= 1'b1;
      r_fcnt    <= '0;
      r_running <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_sx      <= C_HSTA;
          r_sy      <= C_VSTA;
          r_de      <= 1'b0;
          r_hs      <= 1'b1;
          r_vs      <= 1'b1;
          r_line    <= i_start_display;
          r_frame   <= i_start_display;
          r_running <= i_start_display;
          if (i_start_display) r_state <= RUN;
        end
        RUN, STOPPING: begin
          if (w_wrap) r_fcnt <= r_fcnt + C_FCNT_ONE;
          if (w_stop_now) begin
            r_state   <= IDLE;
            r_running <= 1'b0;
            r_sx      <= C_HSTA;
            r_sy      <= C_VSTA;
            r_de      <= 1'b0;
            r_line    <= 1'b0;
            r_frame   <= 1'b0;
            r_hs      <= 1'b1;
            r_vs      <= 1'b1;
          end else begin
            r_running <= 1'b1;
            if (w_wrap)                r_state <= RUN;
            else if (!i_start_display) r_state <= STOPPING;
            r_sx    <= w_nx;
            r_sy    <= w_ny;
            r_de    <= w_n_de;
            r_line  <= w_eol;
            r_frame <= w_wrap;
            r_hs    <= w_n_hs;
            r_vs    <= w_n_vs;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef VGA_TESTPAT_EN
  localparam logic [CORDW-1:0] C_BAR_W = CORDW'(HACT / 8);
  localparam int DW = 27;

  logic [23:0]      r_tp;
  logic [CORDW-1:0] w_nx_u;
  logic [2:0]       w_bar;

  assign w_nx_u = w_nx;
  assign w_bar  = 3'(w_nx_u / C_BAR_W);

  always_ff @(posedge i_clk_25 or negedge i_rst_n) begin
    if (!i_rst_n)                               r_tp <= '0;
    else if (r_state != IDLE && !w_stop_now)    r_tp <= w_n_de ? tp_colour(w_bar) : 24'h0;
    else                                        r_tp <= '0;
  end

  logic [DW-1:0] w_d_in, w_d_out;
  assign w_d_in = {r_hs, r_vs, r_de, r_tp};
  assign {o_tp_r, o_tp_g, o_tp_b} = w_d_out[23:0];
`else
  localparam int DW = 3;
  logic [DW-1:0] w_d_in, w_d_out;
  assign w_d_in = {r_hs, r_vs, r_de};
`endif

  localparam logic [DW-1:0] C_D_RST = {2'b11, {(DW-2){1'b0}}};

  vga_sync_delay #(
    .DEPTH   (SYNC_DELAY),
    .W       (DW),
    .RST_VAL (C_D_RST)
  ) u_sync_delay (
    .i_clk_25 (i_clk_25),
    .i_rst_n  (i_rst_n),
    .i_d      (w_d_in),
    .o_q      (w_d_out)
  );

  assign o_hs        = w_d_out[DW-1];
  assign o_vs        = w_d_out[DW-2];
  assign o_blank_n   = w_d_out[DW-3];
  assign o_sx        = r_sx;
  assign o_sy        = r_sy;
  assign o_de        = r_de;
  assign o_line      = r_line;
  assign o_frame     = r_frame;
  assign o_sync_n    = 1'b0;
  assign o_frame_cnt = r_fcnt;
  assign o_running   = r_running;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a reduced-geometry instance checked cycle by cycle against a
// linear pixel-index model, plus a full 640x480 instance for real line timing.
`timescale 1ns/1ps
module tb_vga_timing_gen;

  localparam int CW  = 16;
  localparam int DLY = 1;
  localparam int FW  = 4;
  localparam int HFP = 4, HSW = 8, HBP = 4, HACT = 16;
  localparam int VFP = 2, VSW = 2, VBP = 3, VACT = 4;
  localparam int HTOT  = HFP + HSW + HBP + HACT;
  localparam int VTOT  = VFP + VSW + VBP + VACT;
  localparam int FRAME = HTOT * VTOT;
  localparam int HSTA  = -(HFP + HSW + HBP);
  localparam int VSTA  = -(VFP + VSW + VBP);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic b_start = 1'b0;
  always #20 clk = ~clk;

  logic [CW-1:0] sx, sy;
  logic          de, line, frame, hs, vs, blank_n, sync_n, running;
  logic [FW-1:0] fcnt;
  logic [1:0]    dbg;
  logic [CW-1:0] b_sx, b_sy;
  logic          b_de, b_line, b_frame, b_hs, b_vs, b_blank_n, b_sync_n, b_running;
  logic [15:0]   b_fcnt;
  logic [1:0]    b_dbg;
`ifdef VGA_TESTPAT_EN
  logic [7:0] tp_r, tp_g, tp_b, b_tp_r, b_tp_g, b_tp_b;
`endif

  vga_timing_gen #(
    .CORDW(CW), .SYNC_DELAY(DLY), .FCNT_W(FW),
    .HFP(HFP), .HSW(HSW), .HBP(HBP), .HACT(HACT),
    .VFP(VFP), .VSW(VSW), .VBP(VBP), .VACT(VACT)
  ) dut (
    .i_clk_25(clk), .i_rst_n(rst_n), .i_start_display(start),
    .o_sx(sx), .o_sy(sy), .o_de(de), .o_line(line), .o_frame(frame),
    .o_hs(hs), .o_vs(vs), .o_blank_n(blank_n), .o_sync_n(sync_n),
    .o_frame_cnt(fcnt), .o_running(running), .o_dbg_state(dbg)
`ifdef VGA_TESTPAT_EN
    , .o_tp_r(tp_r), .o_tp_g(tp_g), .o_tp_b(tp_b)
`endif
  );

  vga_timing_gen #(.CORDW(16), .SYNC_DELAY(0), .FCNT_W(16)) dut_vga (
    .i_clk_25(clk), .i_rst_n(rst_n), .i_start_display(b_start),
    .o_sx(b_sx), .o_sy(b_sy), .o_de(b_de), .o_line(b_line), .o_frame(b_frame),
    .o_hs(b_hs), .o_vs(b_vs), .o_blank_n(b_blank_n), .o_sync_n(b_sync_n),
    .o_frame_cnt(b_fcnt), .o_running(b_running), .o_dbg_state(b_dbg)
`ifdef VGA_TESTPAT_EN
    , .o_tp_r(b_tp_r), .o_tp_g(b_tp_g), .o_tp_b(b_tp_b)
`endif
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;

  function automatic void chk(input string name, input logic signed [63:0] act,
                              input logic signed [63:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp_v, $time);
    end
  endfunction

  function automatic logic [23:0] bar_rgb(input int x);
    case (x / (HACT / 8))
      0: return 24'hFFFFFF;
      1: return 24'hFFFF00;
      2: return 24'h00FFFF;
      3: return 24'h00FF00;
      4: return 24'hFF00FF;
      5: return 24'hFF0000;
      6: return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  // Model: raster position is a pixel index 0..FRAME-1; start only matters at the wrap.
  bit          m_run, m_show;
  int          m_p, m_fcnt, ex, ey;
  logic        e_hs, e_vs, e_de;
  logic [23:0] e_rgb;
  logic [26:0] e_dly;
  logic [26:0] exp_q[$];

  task automatic model_reset();
    m_run = 0; m_show = 0; m_p = 0; m_fcnt = 0;
    exp_q.delete();
    repeat (DLY) exp_q.push_back({1'b1, 1'b1, 1'b0, 24'h0});
  endtask

  task automatic model_step(input bit s);
    if (!m_run) begin
      m_p = 0; m_show = s; m_run = s;
    end else if (m_p == FRAME - 1) begin
      m_fcnt = (m_fcnt + 1) % (1 << FW);
      m_p = 0; m_run = s; m_show = s;
    end else begin
      m_p++; m_show = 1;
    end
    ex = HSTA + m_p % HTOT;
    ey = VSTA + m_p / HTOT;
    e_de  = m_show && ex >= 0 && ey >= 0;
    e_hs  = !(m_show && ex >= HSTA + HFP && ex < HSTA + HFP + HSW);
    e_vs  = !(m_show && ey >= VSTA + VFP && ey < VSTA + VFP + VSW);
    e_rgb = e_de ? bar_rgb(ex) : 24'h0;
    exp_q.push_back({e_hs, e_vs, e_de, e_rgb});
    e_dly = exp_q.pop_front();
  endtask

  task automatic check_all();
    chk("sx", $signed(sx), ex);
    chk("sy", $signed(sy), ey);
    chk("de", de, e_de);
    chk("line", line, m_show && ex == HSTA);
    chk("frame", frame, m_show && m_p == 0);
    chk("hs", hs, e_dly[26]);
    chk("vs", vs, e_dly[25]);
    chk("blank_n", blank_n, e_dly[24]);
    chk("frame_cnt", fcnt, m_fcnt);
    chk("running", running, m_run);
    chk("state_idle", dbg == 2'd0, !m_run);
    chk("sync_n", sync_n, 0);
`ifdef VGA_TESTPAT_EN
    chk("tp_rgb", {tp_r, tp_g, tp_b}, e_dly[23:0]);
`endif
  endtask

  // ---------------- driver ----------------
  task automatic step(input bit s);
    @(negedge clk);
    start = s;
    @(posedge clk);
    #1;
    model_step(s);
    check_all();
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_sx"}, $signed(sx), -16);
    chk({tag, "_sy"}, $signed(sy), -7);
    chk({tag, "_de"}, de, 0);
    chk({tag, "_line"}, line, 0);
    chk({tag, "_frame"}, frame, 0);
    chk({tag, "_hs"}, hs, 1);
    chk({tag, "_vs"}, vs, 1);
    chk({tag, "_blank_n"}, blank_n, 0);
    chk({tag, "_fcnt"}, fcnt, 0);
    chk({tag, "_running"}, running, 0);
    chk({tag, "_vga_hs"}, b_hs, 1);
    chk({tag, "_vga_sx"}, $signed(b_sx), -160);
  endtask

  typedef struct {
    bit start; int sx; int sy; bit line; bit frame; bit run; bit hs;
  } vec_t;

  vec_t vecs[8];
  int   k, len, n_de, n_bl, n_vs, n_hs, fall_sx, rise_sx, fc_before, min_run;
  bit   lv, prev_hs;

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{0, -16, -7, 0, 0, 0, 1};
    vecs[1] = '{0, -16, -7, 0, 0, 0, 1};
    vecs[2] = '{1, -16, -7, 1, 1, 1, 1};
    vecs[3] = '{1, -15, -7, 0, 0, 1, 1};
    vecs[4] = '{0, -14, -7, 0, 0, 1, 1};
    vecs[5] = '{1, -13, -7, 0, 0, 1, 1};
    vecs[6] = '{1, -12, -7, 0, 0, 1, 1};
    vecs[7] = '{1, -11, -7, 0, 0, 1, 0};

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("rst");
    rst_n = 1'b1;
    model_reset();

    // Directed start-up vectors
    for (int i = 0; i < 8; i++) begin
      step(vecs[i].start);
      chk("tbl_sx", $signed(sx), vecs[i].sx);
      chk("tbl_sy", $signed(sy), vecs[i].sy);
      chk("tbl_line", line, vecs[i].line);
      chk("tbl_frame", frame, vecs[i].frame);
      chk("tbl_running", running, vecs[i].run);
      chk("tbl_hs", hs, vecs[i].hs);
    end

    // One whole frame: period, active pixels, delayed blank, vsync width
    k = 0;
    do begin step(1); k++; end while (!frame && k < 2 * FRAME);
    chk("frame_found", frame, 1);
    len = 0; n_de = 0; n_bl = 0; n_vs = 0;
    do begin
      step(1); len++;
      n_de += de; n_bl += blank_n; n_vs += !vs;
    end while (!frame && len < 2 * FRAME);
    chk("frame_period", len, FRAME);
    chk("de_per_frame", n_de, HACT * VACT);
    chk("blank_per_frame", n_bl, HACT * VACT);
    chk("vs_low_per_frame", n_vs, VSW * HTOT);

    // Stop requested mid-frame: raster finishes then idles
    k = 0;
    do begin step(1); k++; end while ($signed(sy) != 1 && k < 2 * FRAME);
    fc_before = fcnt;
    len = 0;
    do begin step(0); len++; end while (running && len < 2 * FRAME);
    chk("stop_latency", len, FRAME - (1 - VSTA) * HTOT);
    chk("stop_sx", $signed(sx), HSTA);
    chk("stop_sy", $signed(sy), VSTA);
    chk("stop_fcnt", fcnt, (fc_before + 1) % (1 << FW));
    n_hs = 0;
    repeat (40) begin step(0); n_hs += line + frame + !hs + !vs; end
    chk("idle_quiet", n_hs, 0);

    // Restart, then drop and re-raise start inside the frame
    step(1);
    chk("restart_frame", frame, 1);
    len = 0; min_run = 1;
    do begin
      len++;
      step((len >= 70 && len < 100) ? 1'b0 : 1'b1);
      if (!running) min_run = 0;
    end while (!frame && len < 2 * FRAME);
    chk("no_gap_period", len, FRAME);
    chk("no_gap_running", min_run, 1);

    // Randomised start level over many frames
    lv = 1'b1;
    repeat (20 * FRAME) begin
      if ($urandom_range(0, 149) == 0) lv = ~lv;
      step(lv);
    end

    // Full-size 640x480 line timing
    b_start = 1'b1;
    k = 0;
    do begin step(1); k++; end while (!b_line && k < 1700);
    chk("vga_line_found", b_line, 1);
    len = 0; n_hs = 0; n_vs = 0; n_de = 0; fall_sx = 9999; rise_sx = 9999; prev_hs = 1'b1;
    do begin
      step(1); len++;
      if (!b_hs) begin
        n_hs++;
        if (prev_hs) fall_sx = $signed(b_sx);
      end else if (!prev_hs) rise_sx = $signed(b_sx);
      prev_hs = b_hs;
      n_vs += !b_vs; n_de += b_de;
    end while (!b_line && len < 1700);
    chk("vga_line_period", len, 800);
    chk("vga_hs_width", n_hs, 96);
    chk("vga_hs_fall_sx", fall_sx, -144);
    chk("vga_hs_rise_sx", rise_sx, -48);
    chk("vga_vs_low", n_vs, 0);
    chk("vga_de_porch", n_de, 0);

    // Asynchronous reset in the middle of an hsync pulse
    k = 0;
    do begin step(1); k++; end while ($signed(sx) != -8 && k < 2 * FRAME);
    chk("hs_pre_rst", hs, 0);
    #5 rst_n = 1'b0;
    b_start = 1'b0;
    #1;
    check_reset_vals("async_rst");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    n_hs = 0;
    repeat (40) begin step(0); n_hs += !hs + !vs; end
    chk("no_sync_after_rst", n_hs, 0);
    repeat (FRAME + 10) step(1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
